jtcps1_obj_dma: RTL and testbench

Copies the CPS1 object (sprite) table out of OBJ VRAM in SDRAM into an on-chip double-buffered table once per frame, at the start of vertical blank. It sits directly downstream of the SDRAM mux OBJ VRAM read slot, which it drives through `vram_obj_addr`, `vram_obj_cs` and `vram_obj_ok`. It feeds the object line scanner through a synchronous read port. The scanner always sees a complete, frame-coherent table while the CPU keeps modifying VRAM.

---
 rtl/jtcps1_pkg.sv | 23 ++
 rtl/jtcps1_obj_dpram.sv | 30 +++
 rtl/jtcps1_obj_dma.sv | 148 ++++++++++++++
 tb/tb_jtcps1_obj_dma.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtcps1_pkg.sv
// Shared definitions for the CPS1 object DMA.
//   obj_dma_state_e : DMA state encoding (idle, request, gap, fill, done)
//   OBJ_FILL_WORD   : word written past the end mark; its high byte is the end mark itself,
//                     so the scanner stops on any of the filled entries
//   obj_word_addr() : SDRAM word address of table entry 'off' for a given MMR base
package jtcps1_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StReq  = 3'd1,
    StGap  = 3'd2,
    StFill = 3'd3,
    StDone = 3'd4
  } obj_dma_state_e;

  localparam logic [15:0] OBJ_FILL_WORD = 16'hFF00;

  // Byte address is base << 8, so the word address is base << 7; wraps modulo 2^23.
  function automatic logic [22:0] obj_word_addr(input logic [15:0] base, input logic [22:0] off);
    return {base, 7'd0} + off;
  endfunction

endpackage

// File: rtl/jtcps1_obj_dpram.sv
// Double-buffered object table storage: 2 x 2^AW x 16 simple dual-port RAM.
//   clk, rstn : clock, async active-low reset (read register only; array is not reset)
//   we, waddr, wdata : DMA write port, waddr = {back bank, index}
//   raddr, dout      : scanner read port, dout registered (1 clock latency)
module jtcps1_obj_dpram #(
  parameter int unsigned AW = 10
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          we,
  input  logic [AW:0]   waddr,
  input  logic [15:0]   wdata,
  input  logic [AW:0]   raddr,
  output logic [15:0]   dout
);

  localparam int unsigned Words = 2 ** (AW + 1);

  logic [15:0] mem [Words];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) dout <= '0;
    else       dout <= mem[raddr];
  end

endmodule

// File: rtl/jtcps1_obj_dma.sv
// CPS1 object table DMA. At each rising edge of VB the object table is copied from OBJ VRAM
// (through the SDRAM mux read slot) into the back half of a double-buffered table; the halves
// are swapped once the copy completes, so the scanner always reads a whole frame's table.
//   clk, rstn                     : clock, async active-low reset
//   VB                            : vertical blank, starts a copy on its rising edge
//   obj_base                      : table base from MMR (byte address = obj_base << 8)
//   vram_obj_addr/cs/data/ok      : SDRAM mux OBJ slot (word address, request, data, valid)
//   tbl_addr, tbl_dout            : scanner read port, 1 clock latency
//   dma_busy                      : copy in progress
module jtcps1_obj_dma
  import jtcps1_pkg::*;
#(
  parameter int unsigned AW       = 10,
  parameter logic [7:0]  END_MARK = 8'hFF
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          VB,
  input  logic [15:0]   obj_base,
  output logic [22:0]   vram_obj_addr,
  output logic          vram_obj_cs,
  input  logic [15:0]   vram_obj_data,
  input  logic          vram_obj_ok,
  input  logic [AW-1:0] tbl_addr,
  output logic [15:0]   tbl_dout,
  output logic          dma_busy
);

  localparam logic [AW-1:0] IdxLast = {AW{1'b1}};

  obj_dma_state_e st;
  logic           vb_l;
  logic           first_req;
  logic           end_hit;
  logic           rd_bank;
  logic [15:0]    base_l;
  logic [AW-1:0]  idx;
  logic [AW-1:0]  idx_inc;
  logic           vb_rise;
  logic           abort;
  logic           we;
  logic [15:0]    wdata;

  assign idx_inc = idx + AW'(1);
  assign vb_rise = VB & ~vb_l;
  // Losing blank mid-copy would leave a torn table, so the copy is dropped.
  assign abort   = ~VB & ((st == StReq) | (st == StGap) | (st == StFill));

  // RAM write strobe. The first REQ cycle ignores ok: the mux may still be presenting
  // data for the previous address.
  always_comb begin
    we    = 1'b0;
    wdata = vram_obj_data;
    unique case (st)
      StReq:  we = ~first_req & vram_obj_ok;
      StFill: begin
        we    = 1'b1;
        wdata = OBJ_FILL_WORD;
      end
      default: we = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st            <= StIdle;
      vb_l          <= 1'b1;  // a reset inside blank must not look like a new blank
      first_req     <= 1'b0;
      end_hit       <= 1'b0;
      rd_bank       <= 1'b0;
      base_l        <= '0;
      idx           <= '0;
      vram_obj_addr <= '0;
      vram_obj_cs   <= 1'b0;
      dma_busy      <= 1'b0;
    end else begin
      vb_l <= VB;
      if (abort) begin
        st          <= StIdle;
        vram_obj_cs <= 1'b0;
        dma_busy    <= 1'b0;
      end else begin
        unique case (st)
          StIdle: begin
            if (vb_rise) begin
              base_l        <= obj_base;
              idx           <= '0;
              vram_obj_addr <= obj_word_addr(obj_base, 23'd0);
              vram_obj_cs   <= 1'b1;
              first_req     <= 1'b1;
              dma_busy      <= 1'b1;
              st            <= StReq;
            end
          end
          StReq: begin
            first_req <= 1'b0;
            if (!first_req && vram_obj_ok) begin
              end_hit     <= (idx[1:0] == 2'd3) && (vram_obj_data[15:8] == END_MARK);
              vram_obj_cs <= 1'b0;
              st          <= StGap;
            end
          end
          StGap: begin
            // An end mark in the very last slot leaves nothing to fill.
            if (end_hit && idx != IdxLast) begin
              idx <= idx_inc;
              st  <= StFill;
            end else if (idx == IdxLast) begin
              dma_busy <= 1'b0;
              st       <= StDone;
            end else begin
              idx           <= idx_inc;
              vram_obj_addr <= obj_word_addr(base_l, 23'(idx_inc));
              vram_obj_cs   <= 1'b1;
              first_req     <= 1'b1;
              st            <= StReq;
            end
          end
          StFill: begin
            idx <= idx_inc;
            if (idx == IdxLast) begin
              dma_busy <= 1'b0;
              st       <= StDone;
            end
          end
          StDone: begin
            rd_bank <= ~rd_bank;
            st      <= StIdle;
          end
          default: st <= StIdle;
        endcase
      end
    end
  end

  jtcps1_obj_dpram #(
    .AW (AW)
  ) u_dpram (
    .clk   (clk),
    .rstn  (rstn),
    .we    (we),
    .waddr ({~rd_bank, idx}),
    .wdata (wdata),
    .raddr ({rd_bank, tbl_addr}),
    .dout  (tbl_dout)
  );

endmodule

// File: tb/tb_jtcps1_obj_dma.sv
module tb_jtcps1_obj_dma;
  import jtcps1_pkg::*;

  localparam int unsigned AW = 10;
  localparam int N = 1024;

  logic          clk = 1'b0;
  logic          rstn;
  logic          VB;
  logic [15:0]   obj_base;
  logic [22:0]   vram_obj_addr;
  logic          vram_obj_cs;
  logic [15:0]   vram_obj_data = 16'h0;
  logic          vram_obj_ok = 1'b0;
  logic [AW-1:0] tbl_addr;
  logic [15:0]   tbl_dout;
  logic          dma_busy;

  always #5 clk = ~clk;

  jtcps1_obj_dma #(.AW(AW), .END_MARK(8'hFF)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .VB            (VB),
    .obj_base      (obj_base),
    .vram_obj_addr (vram_obj_addr),
    .vram_obj_cs   (vram_obj_cs),
    .vram_obj_data (vram_obj_data),
    .vram_obj_ok   (vram_obj_ok),
    .tbl_addr      (tbl_addr),
    .tbl_dout      (tbl_dout),
    .dma_busy      (dma_busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: VRAM words at offsets from the base, and both table banks.
  logic [15:0] vram [N];
  logic [15:0] bank_model [2][N];
  logic        exp_bank = 1'b0;
  logic [15:0] cur_base = 16'h0;
  int          lat = 2;
  bit          stale_ok = 1'b0;

  // Bus monitor state
  logic [22:0] req_log [$];
  int          req_cyc [$];
  int          cyc = 0, cs_fall_cyc = 0, busy_fall_cyc = 0, addr_unstable = 0, flips = 0;
  int          wait_cnt = 0;
  logic        prev_cs = 1'b0, prev_busy = 1'b0, prev_bank = 1'b0;
  logic [22:0] held_addr = '0, last_addr = '0;

  function automatic logic [15:0] vram_word(input logic [22:0] a);
    logic [22:0] off;
    off = a - {cur_base, 7'd0};
    if (off < 23'(N)) return vram[off[AW-1:0]];
    return 16'hDEAD;
  endfunction

  // Monitor and SDRAM slot responder, acting 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (vram_obj_cs && !prev_cs) begin
      req_log.push_back(vram_obj_addr);
      req_cyc.push_back(cyc);
    end
    if (vram_obj_cs && prev_cs && vram_obj_addr !== held_addr) addr_unstable++;
    if (!vram_obj_cs && prev_cs) cs_fall_cyc = cyc;
    if (!dma_busy && prev_busy) busy_fall_cyc = cyc;
    if (dut.rd_bank !== prev_bank) flips++;
    prev_cs   = vram_obj_cs;
    prev_busy = dma_busy;
    prev_bank = dut.rd_bank;
    held_addr = vram_obj_addr;
    if (vram_obj_cs) wait_cnt++;
    else wait_cnt = 0;
    if (stale_ok) begin
      // ok always high, data lagging one cycle behind the address
      vram_obj_ok   = 1'b1;
      vram_obj_data = vram_word(last_addr);
    end else begin
      vram_obj_ok   = vram_obj_cs && (wait_cnt >= lat);
      vram_obj_data = vram_obj_ok ? vram_word(vram_obj_addr) : 16'h0BAD;
    end
    last_addr = vram_obj_addr;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic gen_vram(input int mark, input logic [15:0] mw);
    for (int i = 0; i < N; i++) begin
      vram[i] = 16'($urandom);
      if (i % 4 == 3 && vram[i][15:8] == 8'hFF) vram[i][15:8] = 8'hFE;
    end
    if (mark >= 0) vram[4 * mark + 3] = mw;
  endtask

  // Expected back-bank contents after a complete copy; returns the expected bus read count.
  function automatic int model_copy();
    int last = N - 1;
    for (int k = 0; k < N / 4; k++) begin
      if (vram[4 * k + 3][15:8] == 8'hFF) begin
        last = 4 * k + 3;
        break;
      end
    end
    for (int i = 0; i < N; i++) bank_model[int'(!exp_bank)][i] = (i <= last) ? vram[i] : 16'hFF00;
    return last + 1;
  endfunction

  task automatic start_copy(input logic [15:0] base);
    obj_base = base;
    cur_base = base;
    req_log.delete();
    req_cyc.delete();
    flips = 0;
    addr_unstable = 0;
    @(negedge clk) VB = 1'b0;
    repeat (3) @(negedge clk);
    VB = 1'b1;
  endtask

  task automatic wait_done(output bit done);
    bit seen = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 12000 && !done; i++) begin
      @(negedge clk);
      if (dma_busy) seen = 1'b1;
      else if (seen) done = 1'b1;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic sweep(input string tag);
    int errs = 0;
    int first = -1;
    @(negedge clk) tbl_addr = '0;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      if (tbl_dout !== bank_model[int'(exp_bank)][i]) begin
        if (first < 0) first = i;
        errs++;
      end
      tbl_addr = AW'(i + 1);
    end
    if (first >= 0) $display("  %s: first differing word %0d", tag, first);
    chk(tag, errs, 0);
  endtask

  task automatic check_addrs(input string tag, input logic [15:0] base, input int n);
    int errs = 0;
    logic [22:0] e;
    for (int i = 0; i < req_log.size(); i++) begin
      e = {base, 7'd0} + 23'(i);
      if (req_log[i] !== e) errs++;
    end
    chk({tag, "_count"}, req_log.size(), n);
    chk({tag, "_seq"}, errs, 0);
    chk({tag, "_stable"}, addr_unstable, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          done;
    int          nreads;
    int          errs;
    int          n_at_rst;
    logic [15:0] b;

    rstn     = 1'b0;
    VB       = 1'b0;
    obj_base = 16'h0;
    tbl_addr = '0;
    #1;
    chk("rst_cs", vram_obj_cs, 0);
    chk("rst_addr", vram_obj_addr, 0);
    chk("rst_busy", dma_busy, 0);
    chk("rst_dout", tbl_dout, 0);
    chk("rst_bank", dut.rd_bank, 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    // Full copy, ok two cycles after cs, no end mark
    lat = 2;
    gen_vram(-1, 16'h0);
    nreads = model_copy();
    start_copy(16'h9000);
    wait_done(done);
    chk("full_done", done, 1);
    exp_bank = ~exp_bank;
    check_addrs("full_addr", 16'h9000, nreads);
    chk("full_first", req_log[0], 23'h48_0000);
    chk("full_last", req_log[N-1], 23'h48_03FF);
    chk("full_flips", flips, 1);
    chk("full_bank", dut.rd_bank, exp_bank);
    @(negedge clk) tbl_addr = AW'(5);
    @(negedge clk);
    chk("full_word5", tbl_dout, vram[5]);
    sweep("full_table");

    // End mark at object 3 (word 15)
    lat = $urandom_range(1, 3);
    b = 16'($urandom);
    gen_vram(3, 16'hFF00);
    nreads = model_copy();
    start_copy(b);
    wait_done(done);
    chk("end_done", done, 1);
    exp_bank = ~exp_bank;
    check_addrs("end_addr", b, 16);
    chk("end_nreads", nreads, 16);
    // one GAP cycle then 1008 FILL cycles before DONE
    chk("end_fill_time", busy_fall_cyc - cs_fall_cyc, 1009);
    chk("end_bank", dut.rd_bank, exp_bank);
    sweep("end_table");

    // Abort at idx 200, then restart with a new base
    lat = $urandom_range(1, 3);
    gen_vram(-1, 16'h0);
    start_copy(16'($urandom));
    done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      if (req_log.size() >= 201) done = 1'b1;
    end
    chk("abort_reach200", done, 1);
    VB = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_busy", dma_busy, 0);
    chk("abort_cs", vram_obj_cs, 0);
    chk("abort_flips", flips, 0);
    chk("abort_bank", dut.rd_bank, exp_bank);
    sweep("abort_old_table");
    b = 16'($urandom);
    gen_vram($urandom_range(10, 200), {8'hFF, 8'($urandom)});
    nreads = model_copy();
    start_copy(b);
    wait_done(done);
    chk("restart_done", done, 1);
    exp_bank = ~exp_bank;
    check_addrs("restart_addr", b, nreads);
    sweep("restart_table");

    // ok held high continuously, data lagging the address
    stale_ok = 1'b1;
    gen_vram(40, {8'hFF, 8'($urandom)});
    nreads = model_copy();
    start_copy(16'($urandom));
    wait_done(done);
    chk("stale_done", done, 1);
    exp_bank = ~exp_bank;
    check_addrs("stale_addr", cur_base, nreads);
    errs = 0;
    for (int i = 1; i < req_cyc.size(); i++) if (req_cyc[i] - req_cyc[i-1] != 3) errs++;
    chk("stale_spacing", errs, 0);
    sweep("stale_table");
    stale_ok = 1'b0;

    // Address wrap past the top of SDRAM
    lat = $urandom_range(1, 3);
    gen_vram(63, 16'hFF00);
    nreads = model_copy();
    start_copy(16'hFFFF);
    wait_done(done);
    chk("wrap_done", done, 1);
    exp_bank = ~exp_bank;
    check_addrs("wrap_addr", 16'hFFFF, nreads);
    chk("wrap_top", req_log[127], 23'h7F_FFFF);
    chk("wrap_zero", req_log[128], 23'h00_0000);
    errs = 0;
    foreach (req_log[i]) if ($isunknown(req_log[i])) errs++;
    chk("wrap_noX", errs, 0);
    sweep("wrap_table");

    // Reset in the middle of a copy, with bank 1 currently shown
    chk("mid_pre_bank", dut.rd_bank, 1);
    start_copy(16'($urandom));
    done = 1'b0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk);
      if (req_log.size() >= 5 && vram_obj_cs) done = 1'b1;
    end
    chk("mid_in_req", done, 1);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_cs", vram_obj_cs, 0);
    chk("mid_rst_busy", dma_busy, 0);
    chk("mid_rst_bank", dut.rd_bank, 0);
    chk("mid_rst_addr", vram_obj_addr, 0);
    repeat (2) @(negedge clk);
    n_at_rst = req_log.size();
    rstn = 1'b1;
    repeat (60) @(negedge clk);
    chk("mid_post_busy", dma_busy, 0);
    chk("mid_post_bank", dut.rd_bank, 0);
    chk("mid_post_reqs", req_log.size(), n_at_rst);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
